clk_tick_gen: RTL and testbench

- Parametrised, multi-channel clock-enable and divided-clock generator.
- Replaces the fixed pll/rtc dividers.
- Each channel has a runtime-programmable divider; shadow reload is glitch-free at the terminal count.
- Each channel runs in pulse mode (one-cycle tick) or toggle mode (50% duty level).
- Clients are the UART bit-timing, RTC (mtime) and peripheral-clock logic. The block sits beside the clint and uart in the SoC top.

---
 rtl/clk_tick_gen_if.sv | 27 ++
 rtl/clk_tick_gen.sv | 75 +++++++
 tb/tb_clk_tick_gen.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_tick_gen_if.sv
// rtl/clk_tick_gen_if.sv - control, divider-write and status signals of clk_tick_gen
interface clk_tick_gen_if #(
    parameter int NCH = 2,
    parameter int DW  = 16
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] enable;
    logic [NCH-1:0] mode;
    logic [NCH-1:0] restart;
    logic           div_we;
    logic [SW-1:0]  div_sel;
    logic [DW-1:0]  div_wdata;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] level;
    logic [NCH-1:0] pending;

    modport master (
        output enable, mode, restart, div_we, div_sel, div_wdata,
        input  tick, level, pending
    );

    modport slave (
        input  enable, mode, restart, div_we, div_sel, div_wdata,
        output tick, level, pending
    );
endinterface

// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - multi-channel clock-enable / divided-clock generator with shadowed dividers
module clk_tick_gen #(
    parameter int NCH     = 2,
    parameter int DW      = 16,
    parameter int RST_DIV = 0
) (
    input  logic          clock,
    input  logic          reset,
    clk_tick_gen_if.slave bus
);
    localparam logic [DW-1:0] RST_V = DW'(RST_DIV);

    logic [NCH-1:0] tick_v;
    logic [NCH-1:0] level_v;
    logic [NCH-1:0] pend_v;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] div_q;
        logic [DW-1:0] div_sh;
        logic [DW-1:0] cnt;
        logic [DW-1:0] rv;
        logic          pend;
        logic          tick_q;
        logic          level_q;
        logic          wr_hit;

        // A pending shadow replaces the active divider only when the counter reloads
        assign rv     = pend ? div_sh : div_q;
        assign wr_hit = bus.div_we && (int'(bus.div_sel) == i);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                div_q   <= RST_V;
                div_sh  <= RST_V;
                cnt     <= RST_V;
                pend    <= 1'b0;
                tick_q  <= 1'b0;
                level_q <= 1'b0;
            end else begin
                if (bus.restart[i]) begin
                    cnt     <= rv;
                    div_q   <= rv;
                    pend    <= 1'b0;
                    tick_q  <= 1'b0;
                    level_q <= 1'b0;
                end else if (!bus.enable[i]) begin
                    tick_q  <= 1'b0;
                end else if (cnt == '0) begin
                    tick_q  <= 1'b1;
                    cnt     <= rv;
                    div_q   <= rv;
                    pend    <= 1'b0;
                    level_q <= bus.mode[i] ? ~level_q : 1'b0;
                end else begin
                    cnt     <= cnt - 1'b1;
                    tick_q  <= 1'b0;
                    level_q <= bus.mode[i] & level_q;
                end
                // Placed last so a write coinciding with a reload re-arms the shadow
                if (wr_hit) begin
                    div_sh <= bus.div_wdata;
                    pend   <= 1'b1;
                end
            end
        end

        assign tick_v[i]  = tick_q;
        assign level_v[i] = level_q;
        assign pend_v[i]  = pend;
    end

    assign bus.tick    = tick_v;
    assign bus.level   = level_v;
    assign bus.pending = pend_v;
endmodule

// File: tb/tb_clk_tick_gen.sv
// tb/tb_clk_tick_gen.sv - self-checking bench for clk_tick_gen
module tb_clk_tick_gen;
    localparam int NCH = 2;
    localparam int DW  = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    clk_tick_gen_if #(.NCH(NCH), .DW(DW)) bus ();
    clk_tick_gen_if #(.NCH(3),   .DW(DW)) bus3 ();

    clk_tick_gen #(.NCH(NCH), .DW(DW), .RST_DIV(0)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    clk_tick_gen #(.NCH(3), .DW(DW), .RST_DIV(0)) u_dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    typedef struct {
        logic [1:0]    en;
        logic [1:0]    md;
        logic [1:0]    rs;
        logic          we;
        logic          sel;
        logic [DW-1:0] wd;
        logic [1:0]    tk;
        logic [1:0]    lv;
        logic [1:0]    pd;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_model = 1'b0;

    // Reference: each channel tracks enabled cycles elapsed in the current period
    int m_div   [NCH];
    int m_phase [NCH];
    int m_sh    [NCH];
    bit m_pend  [NCH];
    bit m_tick  [NCH];
    bit m_lvl   [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = 0; m_phase[i] = 0; m_sh[i] = 0;
            m_pend[i] = 0; m_tick[i] = 0; m_lvl[i] = 0;
        end
    endtask

    task automatic model_step();
        int nxt;
        for (int i = 0; i < NCH; i++) begin
            nxt = m_pend[i] ? m_sh[i] : m_div[i];
            if (bus.restart[i]) begin
                m_div[i] = nxt; m_pend[i] = 0; m_phase[i] = 0; m_tick[i] = 0; m_lvl[i] = 0;
            end else if (!bus.enable[i]) begin
                m_tick[i] = 0;
            end else if (m_phase[i] == m_div[i]) begin
                m_tick[i] = 1; m_div[i] = nxt; m_pend[i] = 0; m_phase[i] = 0;
                m_lvl[i] = bus.mode[i] ? !m_lvl[i] : 1'b0;
            end else begin
                m_phase[i]++;
                m_tick[i] = 0;
                if (!bus.mode[i]) m_lvl[i] = 0;
            end
            if (bus.div_we && int'(bus.div_sel) == i) begin
                m_sh[i] = int'(bus.div_wdata); m_pend[i] = 1;
            end
        end
    endtask

    function automatic logic [5:0] model_vec();
        logic [5:0] v;
        for (int i = 0; i < NCH; i++) begin
            v[i] = m_tick[i]; v[2+i] = m_lvl[i]; v[4+i] = m_pend[i];
        end
        return v;
    endfunction

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        if (chk_model) check("model {pending,level,tick}", {bus.pending, bus.level, bus.tick}, model_vec());
    endtask

    task automatic set_in(input logic [1:0] en, input logic [1:0] md, input logic [1:0] rs,
                          input logic we, input logic sel, input logic [DW-1:0] wd);
        bus.enable = en; bus.mode = md; bus.restart = rs;
        bus.div_we = we; bus.div_sel = sel; bus.div_wdata = wd;
    endtask

    task automatic wait_tick(input int ch, output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (bus.tick[ch]) begin n = k; break; end
        end
    endtask

    function automatic vec_t mk(logic [1:0] en, logic [1:0] md, logic [1:0] rs, logic we, logic sel,
                                logic [DW-1:0] wd, logic [1:0] tk, logic [1:0] lv, logic [1:0] pd);
        vec_t v;
        v.en = en; v.md = md; v.rs = rs; v.we = we; v.sel = sel; v.wd = wd;
        v.tk = tk; v.lv = lv; v.pd = pd;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv [9];
        int   n;
        logic [7:0] lv_pat;
        logic [7:0] tk_pat;

        tv[0] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 2'b01, 2'b00, 2'b00);
        tv[1] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 2'b01, 2'b00, 2'b00);
        tv[2] = mk(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 16'd4, 2'b01, 2'b00, 2'b01);
        tv[3] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 2'b01, 2'b00, 2'b00);
        tv[4] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 2'b00, 2'b00, 2'b00);
        tv[5] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 2'b00, 2'b00, 2'b00);
        tv[6] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 2'b00, 2'b00, 2'b00);
        tv[7] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 2'b00, 2'b00, 2'b00);
        tv[8] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 2'b01, 2'b00, 2'b00);

        set_in(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, '0);
        bus3.enable = '0; bus3.mode = '0; bus3.restart = '0;
        bus3.div_we = 1'b0; bus3.div_sel = '0; bus3.div_wdata = '0;
        model_reset();
        #12;
        check("reset tick", bus.tick, 2'b00);
        check("reset level", bus.level, 2'b00);
        check("reset pending", bus.pending, 2'b00);
        reset = 1'b1;

        // Directed table: div=0 pulse mode, then a shadow write of 4 on channel 0
        for (int r = 0; r < 9; r++) begin
            set_in(tv[r].en, tv[r].md, tv[r].rs, tv[r].we, tv[r].sel, tv[r].wd);
            cycle();
            check($sformatf("vec%0d tick", r), bus.tick, tv[r].tk);
            check($sformatf("vec%0d level", r), bus.level, tv[r].lv);
            check($sformatf("vec%0d pending", r), bus.pending, tv[r].pd);
        end

        // Channel 1 toggle mode with div=1
        set_in(2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 16'd1); cycle();
        set_in(2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 16'd0); cycle();
        lv_pat = 8'b0110_0110;
        tk_pat = 8'b1010_1010;
        set_in(2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check($sformatf("toggle level k%0d", k), bus.level[1], lv_pat[k]);
            check($sformatf("toggle tick k%0d", k), bus.tick[1], tk_pat[k]);
        end

        // Channel 0 hold at cnt=2 for 7 cycles
        set_in(2'b11, 2'b10, 2'b01, 1'b0, 1'b0, 16'd0); cycle();
        set_in(2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0); cycle(); cycle();
        set_in(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 7; k++) begin
            cycle();
            check($sformatf("hold tick k%0d", k), bus.tick[0], 1'b0);
        end
        set_in(2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
        cycle(); check("resume tick 1", bus.tick[0], 1'b0);
        cycle(); check("resume tick 2", bus.tick[0], 1'b0);
        cycle(); check("resume tick 3", bus.tick[0], 1'b1);

        // Write coinciding with terminal count, shadow 4 already pending
        set_in(2'b11, 2'b10, 2'b01, 1'b0, 1'b0, 16'd0); cycle();
        set_in(2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 16'd4); cycle();
        set_in(2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0); cycle(); cycle(); cycle();
        set_in(2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 16'd9); cycle();
        check("tc write tick", bus.tick[0], 1'b1);
        check("tc write pending", bus.pending[0], 1'b1);
        set_in(2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
        wait_tick(0, n);
        check("period after tc write", n, 5);
        check("pending after apply", bus.pending[0], 1'b0);
        wait_tick(0, n);
        check("period with new div", n, 10);

        // Out-of-range select on a three-channel instance
        bus3.div_we = 1'b1; bus3.div_sel = 2'd3; bus3.div_wdata = 16'd7;
        cycle();
        check("sel out of range", bus3.pending, 3'b000);
        bus3.div_sel = 2'd2;
        cycle();
        check("sel in range", bus3.pending, 3'b100);
        bus3.div_we = 1'b0;

        // Reset mid-period with level=1 and a pending shadow
        n = 0;
        while (!(bus.level[1] && bus.tick[1]) && n < 8) begin cycle(); n++; end
        check("level high before reset", bus.level[1] && bus.tick[1], 1'b1);
        set_in(2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 16'd5); cycle();
        set_in(2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
        check("level before reset", bus.level[1], 1'b1);
        check("pending before reset", bus.pending[1], 1'b1);
        #3 reset = 1'b0;
        #1;
        check("async reset tick", bus.tick, 2'b00);
        check("async reset level", bus.level, 2'b00);
        check("async reset pending", bus.pending, 2'b00);
        model_reset();
        #1 reset = 1'b1;
        set_in(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0);
        cycle(); check("post reset tick a", bus.tick, 2'b01);
        cycle(); check("post reset tick b", bus.tick, 2'b01);

        // Restart pulse applies a new divider and clears level
        set_in(2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 16'd2); cycle();
        set_in(2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0); cycle();
        set_in(2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 16'd0); cycle();
        check("restart level", bus.level[1], 1'b0);
        check("restart pending", bus.pending[1], 1'b0);
        set_in(2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 16'd0);
        wait_tick(1, n);
        check("period after restart", n, 3);

        // Randomized traffic against the reference
        chk_model = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            bus.enable    = ($urandom_range(0, 7) == 0) ? 2'($urandom) : bus.enable | 2'($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom);
            bus.restart   = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)};
            bus.div_we    = ($urandom_range(0, 7) == 0);
            bus.div_sel   = 1'($urandom);
            bus.div_wdata = 16'($urandom_range(0, 6));
            cycle();
        end
        chk_model = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
